// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B and opcode bytes from uart_rx, then sends the ALU result to uart_tx.
// o_tx_start pulses two cycles after the opcode tick; bytes arriving while a result is in flight are dropped. Timeout: ALU_IF_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_opcode,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_error
);

  typedef enum logic [2:0] {S_A, S_B, S_OP, S_SEND, S_WAIT} state_t;

  state_t state;

`ifdef ALU_IF_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             mid_frame;
  logic             timeout_hit;

  // A byte landing on the expiry cycle suppresses the timeout.
  assign mid_frame   = (state == S_B) || (state == S_OP);
  assign timeout_hit = mid_frame && !i_rx_done_tick && (to_cnt == CNT_LAST);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_opcode   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
`ifdef ALU_IF_TIMEOUT_EN
      o_error    <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      o_tx_start <= 1'b0;
`ifdef ALU_IF_TIMEOUT_EN
      o_error <= 1'b0;
      if (!mid_frame || i_rx_done_tick || timeout_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
`endif
      case (state)
        S_A: begin
          if (i_rx_done_tick) begin
            o_data_a <= i_rx_data;
            state    <= S_B;
          end
        end
        S_B: begin
          if (i_rx_done_tick) begin
            o_data_b <= i_rx_data;
            state    <= S_OP;
          end
        end
        S_OP: begin
          if (i_rx_done_tick) begin
            o_opcode <= i_rx_data[NB_OP-1:0];
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          o_tx_start <= 1'b0;
          if (i_tx_done_tick) begin
            state <= S_A;
          end
        end
        default: state <= S_A;
      endcase
`ifdef ALU_IF_TIMEOUT_EN
      if (timeout_hit) begin
        state   <= S_A;
        o_error <= 1'b1;
      end
`endif
    end
  end

`ifndef ALU_IF_TIMEOUT_EN
  // TIMEOUT_CYCLES is inert here; the comparison is always false for a sane value.
  assign o_error = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

endmodule
